// File: rtl/pc_predict_unit_if.sv
// Resolution bundle from the ID stage into pc_predict_unit.
// master: ID stage drives res_*; slave: pc_predict_unit consumes.
interface pc_predict_unit_if #(
  parameter int WIDTH = 32
);
  logic             res_valid;
  logic [WIDTH-1:0] res_pc;
  logic             res_beq;
  logic             res_bne;
  logic             res_jump;
  logic             res_zero;
  logic [WIDTH-1:0] res_branch_addr;
  logic [WIDTH-1:0] res_jump_addr;
  logic             res_pred_taken;
  logic [WIDTH-1:0] res_pred_target;

  modport master (
    output res_valid, res_pc,
    output res_beq, res_bne, res_jump, res_zero,
    output res_branch_addr, res_jump_addr,
    output res_pred_taken, res_pred_target
  );

  modport slave (
    input res_valid, res_pc,
    input res_beq, res_bne, res_jump, res_zero,
    input res_branch_addr, res_jump_addr,
    input res_pred_taken, res_pred_target
  );
endinterface

// File: rtl/pc_predict_unit.sv
// IF-stage next-PC generator with BTB prediction and ID-stage redirect.
// Ports: clk, rst_n (async low), stall; pc/pred_taken/pred_target out;
// res (slave modport) carries the ID resolution; flush squashes IF/ID.
// PC_PREDICT_BTB_EN defined: direct-mapped BTB with 2-bit counters;
// undefined: static predict-not-taken, no BTB storage.
module pc_predict_unit #(
  parameter int               WIDTH     = 32,
  parameter int               BTB_DEPTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  pc_predict_unit_if.slave res,
  output logic             flush
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_plus4;
  logic             taken;
  logic             is_br;
  logic             mispredict;
  logic [WIDTH-1:0] actual;
  logic [WIDTH-1:0] correct;

  assign pc_plus4 = pc_q + WIDTH'(4);
  assign pc       = pc_q;

  assign is_br = res.res_beq | res.res_bne
               | res.res_jump;
  assign taken = res.res_jump
               | (res.res_beq & res.res_zero)
               | (res.res_bne & ~res.res_zero);
  assign actual = res.res_jump ? res.res_jump_addr
                               : res.res_branch_addr;
  assign correct = taken ? actual
                         : res.res_pc + WIDTH'(4);

  assign mispredict = res.res_valid &
    ((taken != res.res_pred_taken) |
     (taken & (res.res_pred_target != actual)));
  assign flush = mispredict;

`ifdef PC_PREDICT_BTB_EN
  localparam int IDX = $clog2(BTB_DEPTH);
  localparam int TW  = WIDTH - IDX - 2;

  logic             vld_q [BTB_DEPTH];
  logic [TW-1:0]    tag_q [BTB_DEPTH];
  logic [WIDTH-1:0] tgt_q [BTB_DEPTH];
  logic [1:0]       ctr_q [BTB_DEPTH];

  logic [IDX-1:0]   l_idx;
  logic [TW-1:0]    l_tag;
  logic             l_hit;
  logic [IDX-1:0]   u_idx;
  logic [TW-1:0]    u_tag;
  logic             u_hit;
  logic             upd_en;
  logic [WIDTH-1:0] tgt_d;
  logic [1:0]       ctr_d;
  logic [1:0]       ctr_cur;

  assign l_idx = pc_q[IDX+1:2];
  assign l_tag = pc_q[WIDTH-1:IDX+2];
  assign l_hit = vld_q[l_idx] &
                 (tag_q[l_idx] == l_tag);

  assign pred_taken  = l_hit & ctr_q[l_idx][1];
  assign pred_target = pred_taken ? tgt_q[l_idx]
                                  : pc_plus4;

  assign u_idx   = res.res_pc[IDX+1:2];
  assign u_tag   = res.res_pc[WIDTH-1:IDX+2];
  assign u_hit   = vld_q[u_idx] &
                   (tag_q[u_idx] == u_tag);
  assign ctr_cur = ctr_q[u_idx];

  // Miss + not taken leaves the entry untouched.
  assign upd_en = res.res_valid & is_br &
                  (u_hit | taken);

  always_comb begin
    tgt_d = tgt_q[u_idx];
    ctr_d = ctr_cur;
    if (taken) tgt_d = actual;
    if (!u_hit) begin
      ctr_d = res.res_jump ? 2'd3 : 2'd2;
    end else if (res.res_jump) begin
      ctr_d = 2'd3;
    end else if (taken) begin
      if (ctr_cur != 2'd3) ctr_d = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'd0) ctr_d = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'd0;
      end
    end else if (upd_en) begin
      vld_q[u_idx] <= 1'b1;
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= tgt_d;
      ctr_q[u_idx] <= ctr_d;
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
`endif

  // Redirect beats stall: a resolved mispredict must not be lost.
  always_comb begin
    pc_d = pred_target;
    if (mispredict) begin
      pc_d = correct;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit with a scoreboard queue.
// Expectations adapt to whether PC_PREDICT_BTB_EN is defined.
module tb_pc_predict_unit;

`ifdef PC_PREDICT_BTB_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;

  pc_predict_unit_if #(.WIDTH(32)) rif ();

  pc_predict_unit #(
    .WIDTH(32), .BTB_DEPTH(16), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .pc(pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .res(rif.slave),
    .flush(flush)
  );

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic pop(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: got %h want entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: got %h want %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_res();
    rif.res_valid       = 1'b0;
    rif.res_pc          = '0;
    rif.res_beq         = 1'b0;
    rif.res_bne         = 1'b0;
    rif.res_jump        = 1'b0;
    rif.res_zero        = 1'b0;
    rif.res_branch_addr = '0;
    rif.res_jump_addr   = '0;
    rif.res_pred_taken  = 1'b0;
    rif.res_pred_target = '0;
  endtask

  task automatic drive(
    input logic [31:0] rpc, input logic beq,
    input logic bne, input logic jmp,
    input logic zero, input logic [31:0] br,
    input logic [31:0] ja, input logic pt,
    input logic [31:0] ptgt
  );
    rif.res_valid       = 1'b1;
    rif.res_pc          = rpc;
    rif.res_beq         = beq;
    rif.res_bne         = bne;
    rif.res_jump        = jmp;
    rif.res_zero        = zero;
    rif.res_branch_addr = br;
    rif.res_jump_addr   = ja;
    rif.res_pred_taken  = pt;
    rif.res_pred_target = ptgt;
  endtask

  // Not-taken beq wrongly predicted taken: redirects to addr
  // without allocating anything in the BTB.
  task automatic goto_pc(input logic [31:0] addr);
    drive(addr - 32'd4, 1, 0, 0, 0, 32'h0, 32'h0,
          1, 32'hdead_0000);
    #1;
    tick();
    clear_res();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    clear_res();
    #1;
    push("rst_pc", 32'h0);          pop(pc);
    push("rst_pt", 32'h0);          pop({31'b0, pred_taken});
    push("rst_tgt", 32'h4);         pop(pred_target);
    push("rst_flush", 32'h0);       pop({31'b0, flush});

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push("run0", 32'h0);            pop(pc);
    tick();
    push("run4", 32'h4);            pop(pc);
    tick();
    push("run8", 32'h8);            pop(pc);
    push("run_pt", 32'h0);          pop({31'b0, pred_taken});

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      push("stall_hold", 32'h8);    pop(pc);
    end
    stall = 1'b0;
    tick();
    push("unstall", 32'hC);         pop(pc);

    drive(32'h10, 1, 0, 0, 1, 32'h40, 32'h0, 0, 32'h14);
    #1;
    push("beq1_flush", 32'h1);      pop({31'b0, flush});
    tick();
    clear_res();
    push("beq1_pc", 32'h40);        pop(pc);

    goto_pc(32'h10);
    push("fetch10_pc", 32'h10);     pop(pc);
    push("fetch10_pt", 32'(B));     pop({31'b0, pred_taken});
    push("fetch10_tgt", B ? 32'h40 : 32'h14);
    pop(pred_target);

    goto_pc(32'h50);
    push("alias_pt", 32'h0);        pop({31'b0, pred_taken});
    push("alias_tgt", 32'h54);      pop(pred_target);

    drive(32'h10, 0, 1, 0, 1, 32'h40, 32'h0, 1, 32'h40);
    #1;
    push("bne_flush", 32'h1);       pop({31'b0, flush});
    tick();
    clear_res();
    push("bne_pc", 32'h14);         pop(pc);
    goto_pc(32'h10);
    push("weak_pt", 32'h0);         pop({31'b0, pred_taken});
    push("weak_tgt", 32'h14);       pop(pred_target);

    drive(32'h10, 1, 0, 0, 1, 32'h40, 32'h0, 0, 32'h14);
    #1;
    push("beq2_flush", 32'h1);      pop({31'b0, flush});
    tick();
    clear_res();
    goto_pc(32'h10);
    push("relearn_pt", 32'(B));     pop({31'b0, pred_taken});
    drive(32'h10, 1, 0, 0, 1, 32'h40, 32'h0,
          B, B ? 32'h40 : 32'h14);
    #1;
    push("beq3_flush", 32'(!B));    pop({31'b0, flush});
    tick();
    clear_res();
    push("beq3_pc", 32'h40);        pop(pc);

    drive(32'h30, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h34);
    #1;
    push("nonbr_flush", 32'h0);     pop({31'b0, flush});
    clear_res();

    stall = 1'b1;
    drive(32'h20, 0, 0, 1, 0, 32'h0, 32'h100, 0, 32'h24);
    #1;
    push("jmp_flush", 32'h1);       pop({31'b0, flush});
    tick();
    clear_res();
    push("jmp_pc", 32'h100);        pop(pc);
    tick();
    push("jmp_hold", 32'h100);      pop(pc);
    stall = 1'b0;
    goto_pc(32'h20);
    push("fetch20_pt", 32'(B));     pop({31'b0, pred_taken});
    push("fetch20_tgt", B ? 32'h100 : 32'h24);
    pop(pred_target);
    tick();
    push("follow_pred", B ? 32'h100 : 32'h24);
    pop(pc);

    goto_pc(32'hFFFF_FFFC);
    push("wrap_tgt", 32'h0);        pop(pred_target);
    tick();
    push("wrap_pc", 32'h0);         pop(pc);
    tick();
    push("pre_rst_pc", 32'h4);      pop(pc);

    drive(32'h80, 0, 0, 1, 0, 32'h0, 32'h300, 0, 32'h84);
    #1;
    rst_n = 1'b0;
    #1;
    push("async_rst_pc", 32'h0);    pop(pc);
    clear_res();
    tick();
    push("rst_hold_pc", 32'h0);     pop(pc);
    rst_n = 1'b1;
    goto_pc(32'h20);
    push("cleared_20", 32'h0);      pop({31'b0, pred_taken});
    goto_pc(32'h10);
    push("cleared_10", 32'h0);      pop({31'b0, pred_taken});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
